// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR filter and its downstream DAC serialiser.
// The serialiser FSM state type lives here so the bench and other blocks can decode it.
package fir_pkg;

  localparam int SAMPLE_WIDTH = 16;
  localparam int DAC_CLK_DIV  = 2;

  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP
  } dac_state_t;

endpackage

// File: rtl/sclk_divider.sv
// Clock-enable generator for the DAC serial clock: one tick every CLK_DIV cycles,
// split into rise/fall enables while toggling is allowed. No derived clocks.
module sclk_divider #(
  parameter int CLK_DIV = 2
) (
  input  logic ck,
  input  logic rst,
  input  logic start,
  input  logic enable,
  input  logic toggle,
  output logic tick,
  output logic rise_en,
  output logic fall_en
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;
  logic          phase;

  assign tick    = enable && (count == LAST);
  assign rise_en = tick && toggle && !phase;
  assign fall_en = tick && toggle && phase;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      count <= '0;
      phase <= 1'b0;
    end else if (start) begin
      count <= '0;
      phase <= 1'b0;
    end else if (enable) begin
      if (count == LAST) count <= '0;
      else               count <= count + 1'b1;
      if (tick && toggle) phase <= ~phase;
    end
  end

endmodule

// File: rtl/dac_serialiser.sv
// Serialises FIR output samples MSB first into an SPI-like DAC (sclk/sdata/cs_n),
// with a one-deep hold buffer so the FIR never stalls; late samples are dropped and flagged.
module dac_serialiser
  import fir_pkg::*;
#(
  parameter int WIDTH         = SAMPLE_WIDTH,
  parameter int CLK_DIV       = DAC_CLK_DIV,
  parameter int CS_GAP        = 2,
  parameter int CAPTURE_DELAY = 1,
  parameter bit OFFSET_BINARY = 1'b0
) (
  input  logic                    ck,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] sample_in,
  input  logic                    sample_valid,
  output logic                    sclk,
  output logic                    sdata,
  output logic                    cs_n,
  output logic                    busy,
  output logic                    overrun
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [WIDTH-1:0] MSB_FLIP = OFFSET_BINARY ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

  dac_state_t       state, state_nxt;
  logic             capture;
  logic [WIDTH-1:0] capt_word;
  logic [WIDTH-1:0] hold;
  logic             hold_full, hold_full_nxt;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             gap_last, xfer, last_fall;
  logic             tick, rise_en, fall_en;
  logic             sclk_nxt, sdata_nxt, cs_n_nxt, busy_nxt;

  // Capture strobe: either the FIR strobe itself or one cycle later, matching its output register.
  if (CAPTURE_DELAY != 0) begin : g_delay
    logic valid_d;
    always_ff @(posedge ck or posedge rst) begin
      if (rst) valid_d <= 1'b0;
      else     valid_d <= sample_valid;
    end
    assign capture = valid_d;
  end else begin : g_direct
    assign capture = sample_valid;
  end

  assign capt_word = sample_in ^ MSB_FLIP;

  sclk_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .ck      (ck),
    .rst     (rst),
    .start   (xfer),
    .enable  ((state == SETUP) || (state == SHIFT)),
    .toggle  (state == SHIFT),
    .tick    (tick),
    .rise_en (rise_en),
    .fall_en (fall_en)
  );

  always_ff @(posedge ck or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every signal gets a default first, so no path through this block can infer a latch.
  always_comb begin
    state_nxt = state;
    gap_last  = (state == GAP) && (gap_cnt == GW'(CS_GAP - 1));
    xfer      = hold_full && ((state == IDLE) || gap_last);
    last_fall = (state == SHIFT) && fall_en && (bit_cnt == BW'(WIDTH));

    case (state)
      IDLE:    if (hold_full) state_nxt = SETUP;
      SETUP:   if (tick)      state_nxt = SHIFT;
      SHIFT:   if (last_fall) state_nxt = GAP;
      GAP:     if (gap_last)  state_nxt = hold_full ? SETUP : IDLE;
      default:                state_nxt = IDLE;
    endcase

    // A capture always leaves the buffer full: either it was accepted or the held word was kept.
    hold_full_nxt = capture || (hold_full && !xfer);
    cs_n_nxt      = (state_nxt == IDLE) || (state_nxt == GAP);

    sclk_nxt = sclk;
    if (state_nxt != SHIFT) sclk_nxt = 1'b0;
    else if (rise_en)       sclk_nxt = 1'b1;
    else if (fall_en)       sclk_nxt = 1'b0;

    sdata_nxt = sdata;
    if (xfer)          sdata_nxt = hold[WIDTH-1];
    else if (cs_n_nxt) sdata_nxt = 1'b0;
    else if (fall_en)  sdata_nxt = shreg[WIDTH-2];

    busy_nxt = (state_nxt != IDLE) || hold_full_nxt;
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      sclk      <= 1'b0;
      sdata     <= 1'b0;
      cs_n      <= 1'b1;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // The transfer reads the old hold value, so a same-cycle capture can overwrite it safely.
      if (capture && (!hold_full || xfer)) hold <= capt_word;
      if (capture && hold_full && !xfer)   overrun <= 1'b1;
      hold_full <= hold_full_nxt;

      if (xfer)         shreg <= hold;
      else if (fall_en) shreg <= shreg << 1;

      if (xfer)         bit_cnt <= '0;
      else if (rise_en) bit_cnt <= bit_cnt + 1'b1;

      if ((state == GAP) && (state_nxt == GAP)) gap_cnt <= gap_cnt + 1'b1;
      else                                      gap_cnt <= '0;

      sclk  <= sclk_nxt;
      sdata <= sdata_nxt;
      cs_n  <= cs_n_nxt;
      busy  <= busy_nxt;
    end
  end

endmodule
